psum_fifo_reader: RTL and testbench
===================================

Name: psum_fifo_reader

Overview:
- Read-side controller and drain engine for the end-of-row partial-sum FIFO.
- On a start pulse it clears the FIFO read pointer, then issues a programmed number of reads.
- Returned words go through a small skid queue, with optional ReLU, onto a valid/ready stream to the output buffer.
- It owns the FIFO's rd_clr/rd_en/rd_inc pins so the array controller only issues start and waits for done.

Parameters:
DATA_WIDTH, 16, width of one signed partial sum
ADD_WIDTH, 4, FIFO address width; row length counter is ADD_WIDTH+1 bits
Q_DEPTH, 3, skid queue entries (fixed minimum for full throughput; values below 3 are illegal)

Ports:
clk  input  1  single clock
clr  input  1  synchronous reset, active-high
start  input  1  one-cycle pulse; accepted only in IDLE
row_len  input  ADD_WIDTH+1  number of psums to drain; sampled with start
relu_en  input  1  sampled with start; 1 = clamp negative results to 0
fifo_rd_clr  output  1  to FIFO rd_clr; resets its read pointer
fifo_rd_en  output  1  to FIFO rd_en
fifo_rd_inc  output  1  to FIFO rd_inc; equals fifo_rd_en
fifo_rdata  input  DATA_WIDTH  FIFO data_out_fifo, signed; valid the cycle after fifo_rd_en
out_valid  output  1  stream valid
out_ready  input  1  stream ready
out_data  output  DATA_WIDTH  signed psum after optional ReLU
out_last  output  1  high with the final word of the row
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset (clr=1 at a clk edge): state IDLE; all outputs 0; counters, queue and inflight flag cleared.
- clr mid-operation aborts the row; queued data is discarded, and the FIFO pointer is left as is.
- Next start re-clears the FIFO pointer.
- States and transitions:
  - IDLE: start -> CLEAR; latch row_len and relu_en.
  - CLEAR: fifo_rd_clr=1 for exactly one cycle -> DRAIN if len>0, else DONE.
  - DRAIN: issue reads and forward data; -> DONE on the cycle the last word handshakes (out_valid & out_ready & out_last).
  - DONE: done=1 for one cycle -> IDLE.
- start outside IDLE is ignored.
- Read issue rule in DRAIN: fifo_rd_en=1 iff issued<len and occ+inflight<Q_DEPTH.
  - occ = registered queue occupancy; inflight = fifo_rd_en of the previous cycle.
  - This bound guarantees the queue never overflows.
- Capture: when inflight=1, fifo_rdata is pushed into the queue at the clock edge.
- Output:
  - out_data/out_valid come from the queue head (registered).
  - Pop occurs on out_valid & out_ready; push and pop in the same cycle are allowed.
- ReLU: with relu_en latched 1, the MSB-set value becomes 0 at push time. No other arithmetic; width is unchanged.
- out_last = head is word number len (count of popped words = len-1).
- Latency:
  - start in cycle 0 -> fifo_rd_clr in cycle 1 -> first fifo_rd_en in cycle 2 -> out_valid in cycle 4.
  - Sustains one word per cycle while out_ready=1.
- out_valid, once high, holds with stable out_data until accepted.
- Boundary conditions:
  - len=0 yields no reads and no valid; done fires in cycle 2.
  - len=2^ADD_WIDTH is legal; the FIFO pointer wraps naturally.
  - len greater than FIFO_SIZE is a caller error and is not checked.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, CLEAR, DRAIN, DONE);
  - Q_DEPTH constant;
  - a relu helper function used elsewhere in the array.
- One sub-module, psum_skid_q: Q_DEPTH-entry synchronous FIFO with push/pop/occ, synchronous active-high clr.

Test Plan:
- FIFO model returns 5, -3, 7, 32767 for len=4, relu_en=0, out_ready=1:
  - out_data 5, -3, 7, 32767 on consecutive cycles;
  - first out_valid 4 cycles after start; out_last only on 32767;
  - done one cycle after the last handshake.
- Same data with relu_en=1 -> 5, 0, 7, 32767.
- len=8, out_ready low for 6 cycles starting after the first valid:
  - fifo_rd_en stops with at most 3 words held;
  - all 8 words are delivered in order with no loss or duplication.
- len=0 -> fifo_rd_clr pulses once, no fifo_rd_en, no out_valid, done in cycle 2, busy low in cycle 3.
- clr asserted after 2 of 6 words -> next cycle all outputs 0 and state IDLE.
  - A new start with len=3 drains correctly and pulses fifo_rd_clr again.
- start pulsed again while busy -> ignored; row_len is unchanged and exactly one done pulse occurs.

Source files
------------

// File: rtl/psum_fifo_reader_pkg.sv
// Shared definitions for the partial-sum FIFO read path: FSM encoding,
// skid queue depth and the ReLU helper used across the array.
package psum_fifo_reader_pkg;

  // Two reads in flight plus one word waiting on the consumer.
  localparam int Q_DEPTH = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Returns 1 when a word passes through unchanged, 0 when it must be clamped to zero.
  function automatic logic relu_pass(input logic sign_bit, input logic relu_en);
    return !(relu_en && sign_bit);
  endfunction

endpackage

// File: rtl/psum_fifo_reader_if.sv
// FIFO read pins and the output stream of the partial-sum drain engine.
interface psum_fifo_reader_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  fifo_rd_clr;
  logic                  fifo_rd_en;
  logic                  fifo_rd_inc;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  modport master (
    output fifo_rd_clr,
    output fifo_rd_en,
    output fifo_rd_inc,
    input  fifo_rdata,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_last
  );

  modport slave (
    input  fifo_rd_clr,
    input  fifo_rd_en,
    input  fifo_rd_inc,
    output fifo_rdata,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_last
  );
endinterface

// File: rtl/psum_skid_q.sv
// Small synchronous FIFO absorbing FIFO read latency against output back-pressure.
module psum_skid_q #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 3,
  localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OCC_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  head_valid,
  output logic [OCC_W-1:0]      occ
);

  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [OCC_W-1:0] OCC_ONE = 1;

  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [OCC_W-1:0]      occ_reg;
  logic                  do_push;
  logic                  do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_ONE;
  endfunction

  assign do_pop  = pop && (occ_reg != '0);
  assign do_push = push && ((occ_reg != OCC_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (do_pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      if (do_push && !do_pop) begin
        occ_reg <= occ_reg + OCC_ONE;
      end else if (do_pop && !do_push) begin
        occ_reg <= occ_reg - OCC_ONE;
      end
    end
  end

  // Data is forced to zero while empty so an idle stream shows all-zero outputs.
  assign head_valid = (occ_reg != '0);
  assign head_data  = head_valid ? mem_reg[rd_ptr_reg] : '0;
  assign occ        = occ_reg;

endmodule

// File: rtl/psum_fifo_reader.sv
// Drain engine for the end-of-row partial-sum FIFO: clears the read pointer,
// issues row_len reads and streams the returned words out with optional ReLU.
module psum_fifo_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADD_WIDTH  = 4,
  parameter int Q_DEPTH    = psum_fifo_reader_pkg::Q_DEPTH
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 start,
  input  logic [ADD_WIDTH:0]   row_len,
  input  logic                 relu_en,
  output logic                 busy,
  output logic                 done,
  psum_fifo_reader_if.master   bus
);
  import psum_fifo_reader_pkg::*;

  localparam int OCC_W = $clog2(Q_DEPTH + 1);
  localparam logic [ADD_WIDTH:0] CNT_ONE = 1;

  state_t               state_reg;
  state_t               state_next;
  logic [ADD_WIDTH:0]   len_reg;
  logic [ADD_WIDTH:0]   issued_reg;
  logic [ADD_WIDTH:0]   popped_reg;
  logic                 relu_reg;
  logic                 inflight_reg;

  logic                 rd_clr;
  logic                 rd_en;
  logic                 head_valid;
  logic [DATA_WIDTH-1:0] head_data;
  logic [DATA_WIDTH-1:0] push_data;
  logic [OCC_W-1:0]     occ;
  logic                 pop;
  logic                 last;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg    <= ST_IDLE;
      len_reg      <= '0;
      relu_reg     <= 1'b0;
      issued_reg   <= '0;
      popped_reg   <= '0;
      inflight_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= rd_en;
      if (state_reg == ST_IDLE && start) begin
        len_reg  <= row_len;
        relu_reg <= relu_en;
      end
      if (state_reg == ST_CLEAR) begin
        issued_reg <= '0;
        popped_reg <= '0;
      end else begin
        if (rd_en) begin
          issued_reg <= issued_reg + CNT_ONE;
        end
        if (pop) begin
          popped_reg <= popped_reg + CNT_ONE;
        end
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    rd_clr     = 1'b0;
    rd_en      = 1'b0;
    done       = 1'b0;
    busy       = (state_reg != ST_IDLE);
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        rd_clr     = 1'b1;
        state_next = (len_reg != '0) ? ST_DRAIN : ST_DONE;
      end
      ST_DRAIN: begin
        // Counting the read in flight keeps the queue from ever overflowing.
        rd_en = (issued_reg < len_reg) &&
                ((int'(occ) + int'(inflight_reg)) < Q_DEPTH);
        if (pop && last) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign push_data = bus.fifo_rdata &
                     {DATA_WIDTH{relu_pass(bus.fifo_rdata[DATA_WIDTH-1], relu_reg)}};
  assign pop  = head_valid && bus.out_ready;
  assign last = head_valid && (popped_reg == len_reg - CNT_ONE);

  psum_skid_q #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (Q_DEPTH)
  ) u_skid_q (
    .clk        (clk),
    .clr        (clr),
    .push       (inflight_reg),
    .push_data  (push_data),
    .pop        (pop),
    .head_data  (head_data),
    .head_valid (head_valid),
    .occ        (occ)
  );

  assign bus.fifo_rd_clr = rd_clr;
  assign bus.fifo_rd_en  = rd_en;
  assign bus.fifo_rd_inc = rd_en;
  assign bus.out_valid   = head_valid;
  assign bus.out_data    = head_data;
  assign bus.out_last    = last;

endmodule

// File: tb/tb_psum_fifo_reader.sv
// Self-checking bench for psum_fifo_reader: a behavioural FIFO plus an
// expected-word queue built from the row rules, with directed and random rows.
module tb_psum_fifo_reader;

  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          clr;
  logic          start;
  logic [AW:0]   row_len;
  logic          relu_en;
  logic          busy;
  logic          done;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  psum_fifo_reader_if #(.DATA_WIDTH(DW)) bus ();

  psum_fifo_reader #(
    .DATA_WIDTH (DW),
    .ADD_WIDTH  (AW),
    .Q_DEPTH    (3)
  ) dut (
    .clk     (clk),
    .clr     (clr),
    .start   (start),
    .row_len (row_len),
    .relu_en (relu_en),
    .busy    (busy),
    .done    (done),
    .bus     (bus)
  );

  // Behavioural partial-sum FIFO: registered read, pointer cleared by rd_clr.
  logic [DW-1:0] fifo_mem [16];
  logic [AW-1:0] fifo_ptr;

  always @(posedge clk) begin
    if (bus.fifo_rd_clr) begin
      fifo_ptr <= '0;
    end else if (bus.fifo_rd_en) begin
      bus.fifo_rdata <= fifo_mem[fifo_ptr];
      fifo_ptr       <= fifo_ptr + 1'b1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) fifo_mem[i] = DW'($urandom);
  endtask

  // ready_mode: 0 always ready, 1 six stall cycles after first valid, 2 random.
  task automatic run_row(input int len, input bit relu, input int ready_mode,
                         input int restart_cyc, input int abort_pops);
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] v;
    logic [DW-1:0] prev_data;
    int  n_en = 0, n_clr = 0, n_pop = 0, n_done = 0, inc_bad = 0;
    int  first_valid = -1, first_hs = -1, last_hs = -1, done_cyc = -1;
    int  max_held = 0, abort_cyc = -1;
    bit  prev_stall = 0;
    bit  ready_now;

    for (int i = 0; i < len; i++) begin
      v = fifo_mem[i % 16];
      if (relu && v[DW-1]) v = '0;
      exp_q.push_back(v);
    end

    @(posedge clk); #1;
    start = 1'b1; row_len = 5'(len); relu_en = relu; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;

    for (int cyc = 1; cyc <= 300; cyc++) begin
      start   = (cyc == restart_cyc);
      row_len = (cyc == restart_cyc) ? 5'd2 : 5'(len);
      relu_en = (cyc == restart_cyc) ? ~relu : relu;
      case (ready_mode)
        1:       ready_now = !(first_valid >= 0 && cyc > first_valid && cyc <= first_valid + 6);
        2:       ready_now = 1'($urandom_range(0, 1));
        default: ready_now = 1'b1;
      endcase
      bus.out_ready = ready_now;
      if (cyc == abort_cyc) clr = 1'b1;
      @(negedge clk);

      if (cyc == abort_cyc) begin
        @(posedge clk); #1;
        clr = 1'b0;
        @(negedge clk);
        check_eq("abort_ctrl", {busy, done, bus.fifo_rd_clr, bus.fifo_rd_en,
                                bus.fifo_rd_inc, bus.out_valid, bus.out_last}, '0);
        check_eq("abort_data", bus.out_data, '0);
        check_eq("abort_pops", n_pop, abort_pops);
        $display("[TB] row len=%0d aborted after %0d words", len, n_pop);
        return;
      end

      if (cyc == 1) begin
        check_eq("clr_cycle1", bus.fifo_rd_clr, 1'b1);
        check_eq("busy_cycle1", busy, 1'b1);
      end
      if (bus.fifo_rd_clr) n_clr++;
      if (bus.fifo_rd_en) n_en++;
      if (bus.fifo_rd_inc !== bus.fifo_rd_en) inc_bad++;
      if (n_en - n_pop > max_held) max_held = n_en - n_pop;

      if (prev_stall) begin
        check_eq("hold_valid", bus.out_valid, 1'b1);
        check_eq("hold_data", bus.out_data, prev_data);
      end
      if (bus.out_valid && first_valid < 0) first_valid = cyc;

      if (bus.out_valid && ready_now) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_word", n_pop + 1, len);
        end else begin
          v = exp_q.pop_front();
          check_eq("data", bus.out_data, v);
          check_eq("last", bus.out_last, exp_q.size() == 0);
        end
        n_pop++;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        if (abort_pops > 0 && n_pop == abort_pops) abort_cyc = cyc + 1;
      end
      prev_stall = bus.out_valid && !ready_now;
      prev_data  = bus.out_data;

      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) check_eq("busy_after_done", busy, 1'b0);
      if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
      @(posedge clk); #1;
    end

    check_eq("done_seen", done_cyc >= 0, 1'b1);
    check_eq("pops", n_pop, len);
    check_eq("reads", n_en, len);
    check_eq("clr_pulses", n_clr, 1);
    check_eq("done_pulses", n_done, 1);
    check_eq("rd_inc_eq_en", inc_bad, 0);
    if (ready_mode == 1) check_eq("held_max", max_held, 3);
    else                 check_eq("held_le3", max_held <= 3, 1'b1);
    if (len == 0) begin
      check_eq("done_cyc_len0", done_cyc, 2);
      check_eq("no_valid", first_valid, -1);
    end else begin
      check_eq("first_valid", first_valid, 4);
      check_eq("done_after_last", done_cyc, last_hs + 1);
      if (ready_mode == 0) check_eq("throughput", last_hs - first_hs, len - 1);
    end
    $display("[TB] row len=%0d relu=%0d mode=%0d words=%0d first_valid=%0d done_cyc=%0d",
             len, relu, ready_mode, n_pop, first_valid, done_cyc);
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; row_len = '0; relu_en = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    check_eq("reset_ctrl", {busy, done, bus.fifo_rd_clr, bus.fifo_rd_en,
                            bus.fifo_rd_inc, bus.out_valid, bus.out_last}, '0);
    check_eq("reset_data", bus.out_data, '0);

    fifo_mem[0] = 16'd5;
    fifo_mem[1] = -16'sd3;
    fifo_mem[2] = 16'd7;
    fifo_mem[3] = 16'd32767;
    run_row(4, 1'b0, 0, -1, 0);
    run_row(4, 1'b1, 0, -1, 0);

    fill_random();
    run_row(8, 1'b0, 1, -1, 0);
    run_row(0, 1'b0, 0, -1, 0);

    fill_random();
    run_row(6, 1'b0, 0, -1, 2);
    run_row(3, 1'b0, 0, -1, 0);

    fill_random();
    run_row(5, 1'b1, 0, 3, 0);
    run_row(16, 1'b1, 0, -1, 0);

    for (int t = 0; t < 8; t++) begin
      fill_random();
      run_row(int'($urandom_range(0, 16)), 1'($urandom_range(0, 1)), 2, -1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
